fsm_for_matrix_multiplication_accelerator: RTL and testbench

- Control FSM for the matrix-multiplication accelerator, processing one row of C per pass.
- Per row: buffers a row of A into the row register, runs the MAC array against B, then writes the result row of C to BRAM.
- Sequences the BRAM controller, the row register, the MAC array and the row counter through ready/enable handshakes.
- Repeats until the row counter reports full, then returns to idle and pulses finish.

---
 rtl/fsm_for_matrix_multiplication_accelerator.sv | 137 +++++++++++++
 tb/tb_fsm_for_matrix_multiplication_accelerator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_for_matrix_multiplication_accelerator.sv
// ---------------------------------------------------------------------------
// fsm_for_matrix_multiplication_accelerator
//
// Control FSM for the matrix-multiplication accelerator. One pass computes one
// row of C:
//   1. Buffer a row of A into the row register.
//   2. Run the MAC array against B.
//   3. Write the result row of C back to BRAM.
// Passes repeat until the row counter reports full. The FSM then returns to
// idle and pulses finish for one cycle.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, ACTIVE-HIGH (1 = reset)
//   start           begin a multiplication (sampled only in IDLE)
//   register_ready  row register captured the A row
//   fetch_A_ready   BRAM controller delivered the A row
//   MACs_ready      MAC array finished accumulating the row
//   fetch_B_ready   BRAM controller delivered B operands
//   full            row counter at last row (qualified by store_C_ready)
//   store_C_ready   BRAM controller stored the C row
//   register_enable row register load enable
//   MACs_enable     MAC accumulate enable
//   MACs_reset      MAC accumulator clear
//   fetch_A         A-row fetch request
//   fetch_B         B fetch request
//   store_C         C-row store request
//   finish          one-cycle completion pulse
//
// Handshake semantics:
//   Each request output (fetch_A, fetch_B, store_C and their enables) is held
//   high for as long as the FSM stays in the owning state. The FSM leaves that
//   state on the first rising edge where all of that state's ready inputs are
//   high together. A ready input is only looked at in its owning state. It is
//   not latched, so a ready that arrives early or in another state has no
//   effect.
//
// The current state is available as the internal signal "state" (one-hot).
// ---------------------------------------------------------------------------
module fsm_for_matrix_multiplication_accelerator (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic register_ready,
  input  logic fetch_A_ready,
  input  logic MACs_ready,
  input  logic fetch_B_ready,
  input  logic full,
  input  logic store_C_ready,
  output logic register_enable,
  output logic MACs_enable,
  output logic MACs_reset,
  output logic fetch_A,
  output logic fetch_B,
  output logic store_C,
  output logic finish
);

  typedef enum logic [3:0] {
    IDLE                = 4'b0001,
    BUFFER_ROW_A        = 4'b0010,
    MULTIPLY_ACCUMULATE = 4'b0100,
    WRITE_ROW_C         = 4'b1000
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] state;

  logic register_enable_q;
  logic MACs_enable_q;
  logic MACs_reset_q;
  logic fetch_A_q;
  logic fetch_B_q;
  logic store_C_q;
  logic finish_q;
  logic last_row_done;

  assign state = state_q;

  // The final row has been stored. This is the only path back to IDLE that
  // raises finish.
  assign last_row_done = (state_q == WRITE_ROW_C) && store_C_ready && full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = BUFFER_ROW_A;
      end
      BUFFER_ROW_A: begin
        if (fetch_A_ready && register_ready) state_d = MULTIPLY_ACCUMULATE;
      end
      MULTIPLY_ACCUMULATE: begin
        if (fetch_B_ready && MACs_ready) state_d = WRITE_ROW_C;
      end
      WRITE_ROW_C: begin
        if (store_C_ready) state_d = full ? IDLE : BUFFER_ROW_A;
      end
      // Any non-one-hot code recovers to IDLE.
      default: state_d = IDLE;
    endcase
  end

  // The outputs are registered from the next state. This keeps them Moore
  // outputs of the current state while still being flop-driven.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q           <= IDLE;
      register_enable_q <= 1'b0;
      MACs_enable_q     <= 1'b0;
      MACs_reset_q      <= 1'b1;
      fetch_A_q         <= 1'b0;
      fetch_B_q         <= 1'b0;
      store_C_q         <= 1'b0;
      finish_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      register_enable_q <= (state_d == BUFFER_ROW_A);
      fetch_A_q         <= (state_d == BUFFER_ROW_A);
      // Accumulators are held clear in IDLE and while each A row is buffered.
      MACs_reset_q      <= (state_d == IDLE) || (state_d == BUFFER_ROW_A);
      MACs_enable_q     <= (state_d == MULTIPLY_ACCUMULATE);
      fetch_B_q         <= (state_d == MULTIPLY_ACCUMULATE);
      store_C_q         <= (state_d == WRITE_ROW_C);
      finish_q          <= last_row_done;
    end
  end

  assign register_enable = register_enable_q;
  assign MACs_enable     = MACs_enable_q;
  assign MACs_reset      = MACs_reset_q;
  assign fetch_A         = fetch_A_q;
  assign fetch_B         = fetch_B_q;
  assign store_C         = store_C_q;
  assign finish          = finish_q;

endmodule

// File: tb/tb_fsm_for_matrix_multiplication_accelerator.sv
// ---------------------------------------------------------------------------
// Testbench for fsm_for_matrix_multiplication_accelerator.
//
// A behavioural model tracks which step of the row pass the controller should
// be in. It encodes this as a phase number: 0 idle, 1 buffer A, 2 MAC,
// 3 write C. It also tracks whether finish is due. Directed steps run first.
// A randomized stretch follows, and every cycle is compared with the model.
// ---------------------------------------------------------------------------
module tb_fsm_for_matrix_multiplication_accelerator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, register_ready, fetch_A_ready, MACs_ready, fetch_B_ready;
  logic full, store_C_ready;
  logic register_enable, MACs_enable, MACs_reset, fetch_A, fetch_B, store_C;
  logic finish;

  fsm_for_matrix_multiplication_accelerator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .register_ready  (register_ready),
    .fetch_A_ready   (fetch_A_ready),
    .MACs_ready      (MACs_ready),
    .fetch_B_ready   (fetch_B_ready),
    .full            (full),
    .store_C_ready   (store_C_ready),
    .register_enable (register_enable),
    .MACs_enable     (MACs_enable),
    .MACs_reset      (MACs_reset),
    .fetch_A         (fetch_A),
    .fetch_B         (fetch_B),
    .store_C         (store_C),
    .finish          (finish)
  );

  // ---------------- scoreboard state ----------------
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_phase;    // 0 idle, 1 buffer A, 2 MAC, 3 write C
  logic m_finish;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from which job the pass is doing in each phase.
  task automatic check_all(input string tag);
    logic [3:0] onehot;
    onehot = 4'b0001 << m_phase;
    chk({tag, "_state"},   dut.state,            onehot);
    chk({tag, "_fetchA"},  {3'b0, fetch_A},         {3'b0, m_phase == 1});
    chk({tag, "_regen"},   {3'b0, register_enable}, {3'b0, m_phase == 1});
    chk({tag, "_macrst"},  {3'b0, MACs_reset},      {3'b0, m_phase <= 1});
    chk({tag, "_macen"},   {3'b0, MACs_enable},     {3'b0, m_phase == 2});
    chk({tag, "_fetchB"},  {3'b0, fetch_B},         {3'b0, m_phase == 2});
    chk({tag, "_storeC"},  {3'b0, store_C},         {3'b0, m_phase == 3});
    chk({tag, "_finish"},  {3'b0, finish},          {3'b0, m_finish});
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_clock();
    logic nf;
    nf = (m_phase == 3) && store_C_ready && full;
    case (m_phase)
      0: if (start) m_phase = 1;
      1: if (fetch_A_ready && register_ready) m_phase = 2;
      2: if (fetch_B_ready && MACs_ready) m_phase = 3;
      default: if (store_C_ready) m_phase = full ? 0 : 1;
    endcase
    m_finish = nf;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    start = 0; register_ready = 0; fetch_A_ready = 0; MACs_ready = 0;
    fetch_B_ready = 0; full = 0; store_C_ready = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  // One row pass from BUFFER_ROW_A through WRITE_ROW_C. Outputs are checked
  // after every edge. The store handshake waits two cycles before completing.
  task automatic row_pass(input logic last);
    clear_in(); fetch_A_ready = 1; register_ready = 1;
    step("to_mac");
    chk("to_mac_code", dut.state, 4'b0100);
    clear_in(); fetch_B_ready = 1; MACs_ready = 1;
    step("to_wr");
    chk("to_wr_code", dut.state, 4'b1000);
    clear_in(); full = last;
    step("wr_hold0");
    step("wr_hold1");
    clear_in(); store_C_ready = 1; full = last;
    step(last ? "to_idle" : "to_buf");
    chk("after_wr_code", dut.state, last ? 4'b0001 : 4'b0010);
    clear_in();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_in();
    m_phase  = 0;
    m_finish = 0;
    rst_n    = 1;
    #7;
    check_all("in_reset");
    #1 rst_n = 0;
    #1 check_all("post_reset");

    // First run: four rows. Only the fourth row ends with full=1.
    start = 1;
    step("to_buf_first");
    chk("first_buf_code", dut.state, 4'b0010);
    clear_in();
    for (int r = 0; r < 4; r++) row_pass(r == 3);
    chk("finish_pulse", {3'b0, finish}, 4'b0001);
    step("finish_drop");
    chk("finish_gone", {3'b0, finish}, 4'b0000);

    // A ready from the wrong state must not be remembered.
    fetch_B_ready = 1; MACs_ready = 1; store_C_ready = 1;
    step("idle_stray");
    clear_in();

    // Partial handshakes keep the state.
    start = 1;
    step("p_to_buf");
    clear_in(); fetch_A_ready = 1;
    step("p_a_only");
    clear_in(); register_ready = 1;
    step("p_reg_only");
    chk("p_buf_hold", dut.state, 4'b0010);
    clear_in(); fetch_A_ready = 1; register_ready = 1;
    step("p_to_mac");
    clear_in(); MACs_ready = 1;
    step("p_mac_only");
    clear_in(); fetch_B_ready = 1;
    step("p_fb_only");
    chk("p_mac_hold", dut.state, 4'b0100);

    // Reset asserted mid-run, away from any clock edge.
    clear_in();
    #2 rst_n = 1;
    m_phase = 0; m_finish = 0;
    #1 check_all("mid_rst");
    chk("mid_rst_macen", {3'b0, MACs_enable}, 4'b0000);
    #1 rst_n = 0;
    step("after_mid_rst");

    // Randomized traffic checked against the model each cycle.
    for (int i = 0; i < 400; i++) begin
      start          = ($urandom_range(0, 3) == 0);
      fetch_A_ready  = $urandom_range(0, 1);
      register_ready = $urandom_range(0, 1);
      fetch_B_ready  = $urandom_range(0, 1);
      MACs_ready     = $urandom_range(0, 1);
      store_C_ready  = $urandom_range(0, 1);
      full           = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
